cpuc_reg_bank: RTL and testbench
================================

Name: cpuc_reg_bank

Overview:
- Parametrised register bank plus program counter for the CPUC fabric; the successor to the fixed 8-register/1-PC output bundle.
- Each architectural register loads, per instruction, from any one component output or constant, chosen through a per-register crossbar select.
- The PC sequences through the instruction memory with jump and halt support.
- Drives the packed register and PC output bus consumed by every component input mux.

Parameters:
- DATA_WIDTH, 32, register and source data width.
- NUM_OF_REGS, 8, number of architectural registers (1..64).
- NUM_OF_SRCS, 16, number of selectable sources (component outputs plus constants).
- PROGRAM_SIZE, 32, instruction memory depth; PC_WIDTH = $clog2(PROGRAM_SIZE).
- SEL_WIDTH, $clog2(NUM_OF_SRCS+1), per-register select width.

Ports:
- Clk  in  1  clock.
- RstN  in  1  asynchronous active-low reset.
- Start  in  1  pulse: begin program execution from PC=0.
- Stall  in  1  freeze: no register writes and no PC advance this cycle.
- Clear  in  1  synchronous clear of all registers to 0.
- Src_vec  in  NUM_OF_SRCS*DATA_WIDTH  source data; source k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- Reg_sel  in  NUM_OF_REGS*SEL_WIDTH  per-register source index.
- Reg_we  in  NUM_OF_REGS  per-register write enable.
- Pc_jump  in  1  take jump this instruction.
- Pc_target  in  PC_WIDTH  jump destination.
- Halt_inst  in  1  current instruction is halt.
- Reg_outputs  out  (NUM_OF_REGS+1)*DATA_WIDTH  registers 0..N-1, then the PC zero-extended in the top slot.
- Pc  out  PC_WIDTH  current program counter.
- Running  out  1  high in RUN.
- Done  out  1  high in HALT.

Behaviour:
- Reset (RstN=0, asynchronous):
  - all registers 0, Pc 0, state IDLE.
  - Running 0, Done 0.
  - Reset mid-RUN aborts immediately; no partial write survives.
- States IDLE, RUN, HALT.
  - IDLE: Start → RUN with Pc=0.
  - RUN: Start is ignored.
  - HALT: Start → RUN with Pc=0; register contents are kept.
- Instruction commit happens in RUN with Stall=0, at the clock edge:
  - for each r with Reg_we[r]=1 and Reg_sel[r] < NUM_OF_SRCS: reg[r] ← Src_vec[Reg_sel[r]].
  - a select ≥ NUM_OF_SRCS means hold (no write), even if Reg_we[r]=1.
  - multiple registers may load in the same cycle, including from the same source.
- PC update on commit:
  - Halt_inst=1 → Pc holds, state → HALT. Halt has priority over jump.
  - else Pc_jump=1 → Pc ← Pc_target. A target ≥ PROGRAM_SIZE wraps modulo 2^PC_WIDTH, with no check.
  - else Pc = PROGRAM_SIZE-1 → state → HALT, Pc holds (implicit end of program).
  - else Pc ← Pc+1.
- Writes of the halting instruction still commit.
- Stall=1 in RUN: registers and Pc hold; Halt_inst and Pc_jump are ignored.
- Clear=1:
  - all registers ← 0 in any state.
  - priority over same-cycle writes; Pc and state are unaffected.
- Outside RUN: Reg_we, Pc_jump and Halt_inst are ignored.
- Latency: a register loaded at edge t is visible on Reg_outputs after edge t (1 cycle).
- Running = (state==RUN); Done = (state==HALT). Both are registered.

Optional Feature:
- CPUC_REG_BYPASS_EN defined:
  - Reg_outputs slot r shows the value being committed this cycle (write-through, combinational) when a valid write to r is enabled in RUN without Stall.
  - Clear forces 0 in the bypass path.
  - The PC slot is never bypassed.
- Undefined: Reg_outputs is purely registered (default).

Test Plan:
- Reset then Start, Reg_we=0, no jump/halt → Pc counts 0..31, Done rises the cycle after Pc=31 commits, Running falls together with it.
- RUN, Src_vec[3]=0xDEADBEEF, Reg_sel[0]=3, Reg_sel[5]=3, Reg_we=0x21 → reg0 = reg5 = 0xDEADBEEF next cycle; other registers 0.
- RUN at Pc=4, Pc_jump=1, Pc_target=20 → Pc=20. Next cycle Halt_inst=1 with Pc_jump=1 and Reg_we[1]=1 → reg1 written, Pc stays 20, Done=1.
- RUN, Stall=1 with Reg_we=0xFF and Halt_inst=1 → no register change, Pc holds, state stays RUN. Stall=0 → normal commit.
- Reg_sel[2]=NUM_OF_SRCS (out of range) with Reg_we[2]=1 → reg2 unchanged. Clear=1 with Reg_we[0]=1 → reg0=0.
- Assert RstN=0 mid-RUN at Pc=7 → asynchronously Pc=0, registers 0, Running=0. Release, then Start → execution restarts at Pc=0.

Source files
------------

// File: rtl/cpuc_reg_bank.sv
// CPUC register bank plus program counter with IDLE/RUN/HALT sequencing.
// Optional write-through bypass on register slots when CPUC_REG_BYPASS_EN is defined.
module cpuc_reg_bank #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_OF_REGS  = 8,
  parameter int unsigned NUM_OF_SRCS  = 16,
  parameter int unsigned PROGRAM_SIZE = 32,
  parameter int unsigned PC_WIDTH     = $clog2(PROGRAM_SIZE),
  parameter int unsigned SEL_WIDTH    = $clog2(NUM_OF_SRCS + 1)
) (
  input  logic                                   Clk,
  input  logic                                   RstN,
  input  logic                                   Start,
  input  logic                                   Stall,
  input  logic                                   Clear,
  input  logic [NUM_OF_SRCS*DATA_WIDTH-1:0]      Src_vec,
  input  logic [NUM_OF_REGS*SEL_WIDTH-1:0]       Reg_sel,
  input  logic [NUM_OF_REGS-1:0]                 Reg_we,
  input  logic                                   Pc_jump,
  input  logic [PC_WIDTH-1:0]                    Pc_target,
  input  logic                                   Halt_inst,
  output logic [(NUM_OF_REGS+1)*DATA_WIDTH-1:0]  Reg_outputs,
  output logic [PC_WIDTH-1:0]                    Pc,
  output logic                                   Running,
  output logic                                   Done
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  localparam logic [PC_WIDTH-1:0] LastPc = PC_WIDTH'(PROGRAM_SIZE - 1);

  state_e                                  state_q;
  logic [PC_WIDTH-1:0]                     pc_q;
  logic                                    running_q;
  logic                                    done_q;
  logic [NUM_OF_REGS-1:0][DATA_WIDTH-1:0]  regs_q;
  logic [NUM_OF_REGS-1:0][DATA_WIDTH-1:0]  regs_d;
  logic [NUM_OF_REGS-1:0][DATA_WIDTH-1:0]  wdata;
  logic [NUM_OF_REGS-1:0]                  wr_valid;
  logic [SEL_WIDTH-1:0]                    sel;
  logic                                    commit;

  assign commit = (state_q == StRun) && !Stall;

  // Per-register crossbar; selects at or above NUM_OF_SRCS mean hold.
  always_comb begin
    wr_valid = '0;
    wdata    = '0;
    regs_d   = regs_q;
    sel      = '0;
    for (int unsigned r = 0; r < NUM_OF_REGS; r++) begin
      sel = Reg_sel[r*SEL_WIDTH +: SEL_WIDTH];
      for (int unsigned k = 0; k < NUM_OF_SRCS; k++) begin
        if (32'(sel) == k) begin
          wdata[r] = Src_vec[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      wr_valid[r] = commit && Reg_we[r] && (32'(sel) < NUM_OF_SRCS);
      if (Clear) begin
        regs_d[r] = '0;
      end else if (wr_valid[r]) begin
        regs_d[r] = wdata[r];
      end
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StHalt: begin
          if (Start) begin
            state_q   <= StRun;
            pc_q      <= '0;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        StRun: begin
          if (!Stall) begin
            if (Halt_inst || (!Pc_jump && (pc_q == LastPc))) begin
              state_q   <= StHalt;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end else if (Pc_jump) begin
              pc_q <= Pc_target;
            end else begin
              pc_q <= pc_q + PC_WIDTH'(1);
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    Reg_outputs = '0;
    for (int unsigned r = 0; r < NUM_OF_REGS; r++) begin
`ifdef CPUC_REG_BYPASS_EN
      if (wr_valid[r]) begin
        Reg_outputs[r*DATA_WIDTH +: DATA_WIDTH] = Clear ? '0 : wdata[r];
      end else begin
        Reg_outputs[r*DATA_WIDTH +: DATA_WIDTH] = regs_q[r];
      end
`else
      Reg_outputs[r*DATA_WIDTH +: DATA_WIDTH] = regs_q[r];
`endif
    end
    Reg_outputs[NUM_OF_REGS*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(pc_q);
  end

  assign Pc      = pc_q;
  assign Running = running_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_cpuc_reg_bank.sv
// Directed self-checking bench for cpuc_reg_bank in its default configuration.
module tb_cpuc_reg_bank;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 8;
  localparam int unsigned NS = 16;
  localparam int unsigned PS = 32;
  localparam int unsigned PW = 5;
  localparam int unsigned SW = 5;

  logic                  Clk = 1'b0;
  logic                  RstN;
  logic                  Start;
  logic                  Stall;
  logic                  Clear;
  logic [NS*DW-1:0]      Src_vec;
  logic [NR*SW-1:0]      Reg_sel;
  logic [NR-1:0]         Reg_we;
  logic                  Pc_jump;
  logic [PW-1:0]         Pc_target;
  logic                  Halt_inst;
  logic [(NR+1)*DW-1:0]  Reg_outputs;
  logic [PW-1:0]         Pc;
  logic                  Running;
  logic                  Done;

  int total = 0;
  int bad   = 0;

  cpuc_reg_bank #(
    .DATA_WIDTH  (DW),
    .NUM_OF_REGS (NR),
    .NUM_OF_SRCS (NS),
    .PROGRAM_SIZE(PS)
  ) dut (
    .Clk        (Clk),
    .RstN       (RstN),
    .Start      (Start),
    .Stall      (Stall),
    .Clear      (Clear),
    .Src_vec    (Src_vec),
    .Reg_sel    (Reg_sel),
    .Reg_we     (Reg_we),
    .Pc_jump    (Pc_jump),
    .Pc_target  (Pc_target),
    .Halt_inst  (Halt_inst),
    .Reg_outputs(Reg_outputs),
    .Pc         (Pc),
    .Running    (Running),
    .Done       (Done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] slot(input int unsigned r);
    return Reg_outputs[r*DW +: DW];
  endfunction

  task automatic set_sel(input int unsigned r, input logic [SW-1:0] v);
    Reg_sel[r*SW +: SW] = v;
  endtask

  task automatic set_src(input int unsigned k, input logic [DW-1:0] v);
    Src_vec[k*DW +: DW] = v;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_all_regs(input string tag, input logic [31:0] exp);
    for (int r = 0; r < NR; r++) chk($sformatf("%s_r%0d", tag, r), slot(r), exp);
  endtask

  initial begin
    RstN = 1'b0; Start = 1'b0; Stall = 1'b0; Clear = 1'b0;
    Src_vec = '0; Reg_sel = '0; Reg_we = '0;
    Pc_jump = 1'b0; Pc_target = '0; Halt_inst = 1'b0;
    for (int k = 0; k < NS; k++) set_src(k, 32'h1000_0000 + 32'(k));
    #1;
    chk("rst_pc", 32'(Pc), 32'd0);
    chk("rst_running", 32'(Running), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk_all_regs("rst", 32'd0);
    tick(); tick();
    RstN = 1'b1;

    // Free run through the whole program with no writes.
    tick();
    chk("idle_running", 32'(Running), 32'd0);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("start_running", 32'(Running), 32'd1);
    chk("start_pc", 32'(Pc), 32'd0);
    for (int i = 1; i < PS; i++) begin
      tick();
      chk($sformatf("count_pc%0d", i), 32'(Pc), 32'(i));
    end
    chk("pc31_running", 32'(Running), 32'd1);
    chk("pc31_done", 32'(Done), 32'd0);
    chk("pc_slot31", slot(NR), 32'd31);
    tick();
    chk("end_done", 32'(Done), 32'd1);
    chk("end_running", 32'(Running), 32'd0);
    chk("end_pc", 32'(Pc), 32'd31);

    // Restart from HALT, then fan one source into two registers.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("restart_pc", 32'(Pc), 32'd0);
    chk("restart_done", 32'(Done), 32'd0);
    set_src(3, 32'hDEAD_BEEF);
    set_sel(0, 5'd3); set_sel(5, 5'd3);
    Reg_we = 8'h21;
    tick();
    Reg_we = '0;
    chk("fan_r0", slot(0), 32'hDEAD_BEEF);
    chk("fan_r5", slot(5), 32'hDEAD_BEEF);
    chk("fan_r1", slot(1), 32'd0);
    chk("fan_r4", slot(4), 32'd0);
    chk("fan_pc", 32'(Pc), 32'd1);

    // Jump at Pc=4, then halt with a pending jump and a write.
    tick(); tick(); tick();
    chk("prejump_pc", 32'(Pc), 32'd4);
    Pc_jump = 1'b1; Pc_target = 5'd20;
    tick();
    chk("jump_pc", 32'(Pc), 32'd20);
    set_src(7, 32'h1234_5678);
    set_sel(1, 5'd7);
    Reg_we = 8'h02; Halt_inst = 1'b1; Pc_target = 5'd5;
    tick();
    Reg_we = '0; Halt_inst = 1'b0; Pc_jump = 1'b0;
    chk("halt_r1", slot(1), 32'h1234_5678);
    chk("halt_pc", 32'(Pc), 32'd20);
    chk("halt_done", 32'(Done), 32'd1);
    chk("halt_running", 32'(Running), 32'd0);

    // Writes are ignored outside RUN.
    for (int r = 0; r < NR; r++) set_sel(r, 5'd7);
    Reg_we = 8'hFF;
    tick();
    Reg_we = '0;
    chk("haltwe_r2", slot(2), 32'd0);
    chk("haltwe_r0", slot(0), 32'hDEAD_BEEF);

    // Stall freezes everything, including halt.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("kept_r5", slot(5), 32'hDEAD_BEEF);
    Stall = 1'b1; Reg_we = 8'hFF; Halt_inst = 1'b1;
    tick(); tick();
    chk("stall_r2", slot(2), 32'd0);
    chk("stall_pc", 32'(Pc), 32'd0);
    chk("stall_running", 32'(Running), 32'd1);
    Stall = 1'b0; Halt_inst = 1'b0;
    tick();
    Reg_we = '0;
    chk_all_regs("unstall", 32'h1234_5678);
    chk("unstall_pc", 32'(Pc), 32'd1);

    // Out-of-range select holds; Clear beats a write.
    set_src(0, 32'hA5A5_A5A5);
    for (int r = 0; r < NR; r++) set_sel(r, 5'd0);
    set_sel(2, 5'd16);
    Reg_we = 8'h04;
    tick();
    chk("oor16_r2", slot(2), 32'h1234_5678);
    set_sel(2, 5'd31);
    tick();
    chk("oor31_r2", slot(2), 32'h1234_5678);
    Reg_we = 8'h01; Clear = 1'b1;
    tick();
    Reg_we = '0; Clear = 1'b0;
    chk_all_regs("clear", 32'd0);
    chk("clear_pc", 32'(Pc), 32'd4);
    chk("clear_running", 32'(Running), 32'd1);

    // Async reset mid-run at Pc=7.
    set_sel(3, 5'd0);
    Reg_we = 8'h08;
    tick();
    Reg_we = '0;
    chk("pre_rst_r3", slot(3), 32'hA5A5_A5A5);
    tick(); tick();
    chk("pre_rst_pc", 32'(Pc), 32'd7);
    #2;
    RstN = 1'b0;
    #1;
    chk("arst_pc", 32'(Pc), 32'd0);
    chk("arst_running", 32'(Running), 32'd0);
    chk("arst_r3", slot(3), 32'd0);
    #2;
    RstN = 1'b1;
    tick();
    chk("post_rst_idle", 32'(Running), 32'd0);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("rerun_running", 32'(Running), 32'd1);
    chk("rerun_pc0", 32'(Pc), 32'd0);
    tick();
    chk("rerun_pc1", 32'(Pc), 32'd1);
    chk("rerun_slot", slot(NR), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
